mean_update: RTL
================

Name: mean_update

Overview:
- Consumer of the cluster engine's per-cluster accumulator sums and pixel counters at the end of a K-means pass.
- Divides each channel sum by its cluster's pixel count to produce the next set of means.
- Feeds the new means back to the engine's meanIn bus.
- Sequential: one shared serial divider, time-multiplexed over all clusters and channels under an FSM.

Parameters:
- T, 16, number of clusters.
- ACC_W, 72, accumulator width per cluster: 3 channels × 24-bit sums.
- CNT_W, 12, pixel counter width per cluster.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a mean update; sampled only in IDLE.
- accumolator  input  ACC_W*T  per-cluster sums; cluster i at [i*72+:72], channel c sum at [c*24+:24] within it.
- counters  input  CNT_W*T  per-cluster pixel counts; cluster i at [i*12+:12].
- meanIn  input  24*T  current means; cluster i at [i*24+:24], channel c at [c*8+:8].
- enabled  input  T  cluster-active mask.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse when meanOut is updated.
- meanOut  output  24*T  new means, same packing as meanIn.
- empty  output  T  bit i set if cluster i was enabled with count 0 in the last update.
- changed  output  1  set if any meanOut cluster differs from its snapshot meanIn value.

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE; busy=0, done=0, changed=0.
  - meanOut=0, empty=0; snapshot and divider state cleared.
  - Reset mid-operation aborts silently: no done pulse, outputs as above.
- IDLE:
  - start=1 at an edge → snapshot registers capture accumolator, counters, meanIn, enabled; go to SETUP with index i=0, c=0.
  - The engine may clear its accumulators from the next cycle on.
- SETUP (1 cycle): load divider with dividend = snapshot sum[i][c] (24 b) and divisor = count[i] (12 b).
- ITER (exactly 24 cycles):
  - Restoring division, one quotient bit per cycle, MSB first; result is floor(sum/count).
  - On the last ITER cycle the result is written to the staging register for [i][c]:
    - enabled[i]=1 and count≠0: min(quotient,255).
    - Otherwise: snapshot meanIn[i][c] (pass-through).
  - Division by zero is still iterated for fixed timing; its result is discarded.
  - Then advance c; c wraps 2→0 with i+1. Next state is SETUP, or DONE after i=T-1, c=2.
- DONE (1 cycle):
  - meanOut ← staging, all clusters at once.
  - empty[i] ← enabled[i] & (count[i]==0).
  - changed ← (staging ≠ snapshot meanIn).
  - done=1, busy=1; next state IDLE.
- Latency: fixed and data-independent.
  - start sampled at edge k → done high in cycle k+1+25·3T+1 region; exactly 1+75T+1 = 1202 edges from start to done fall for T=16.
  - The bench checks the done edge at start edge + 1 + 75T.
- start while busy is ignored; no queueing.
- start is accepted on the edge immediately after done (FSM already in IDLE).
- meanOut, empty and changed hold between updates and change only in DONE.
- Width rules:
  - Remainder register 13 b so the subtraction carry is kept.
  - Quotient register 24 b; saturation to 8 b is applied only at writeback.

Decomposition:
- Shared package (cluster_pkg), constants:
  - CH_N=3, CH_W=8, SUM_W=24, CNT_W=12, T.
  - Channel offset macros for mean and accumulator slices, shared with cluster_engine.
  - FSM state encodings.
- One sub-module: serial_divider (24/12 restoring).
  - Ports: clk, reset, load, dividend, divisor, quotient, valid.
  - Fixed 24-cycle latency after load.
- The top holds the FSM, snapshot, staging and output registers.

Test Plan:
- Cluster 0: sums R=2550, G=1000, B=10, count=10, enabled → meanOut[0] channels = 255, 100, 1; done exactly 1+75T edges after start; changed=1 when meanIn[0]=0.
- Cluster 3 enabled, count=0, meanIn[3]=0x123456 → meanOut[3]=0x123456, empty[3]=1, other empty bits 0.
- enabled[5]=0, count=7, sums nonzero, meanIn[5]=0xABCDEF → meanOut[5]=0xABCDEF, empty[5]=0.
- Rounding and saturation:
  - sum=0xFFFFFF, count=1 → channel=255.
  - sum=7, count=2 → 3 (floor).
  - sum=4095·255, count=4095 → 255.
- All means equal the computed values (meanIn preloaded with expected results) → changed=0; start pulsed mid-operation has no effect on done timing.
- reset asserted 300 cycles after start → busy=0, meanOut=0, no done pulse. After release, a fresh start completes normally with the same expected values.

Source files
------------

// File: rtl/cluster_pkg.sv
// Shared constants, FSM state type and bus-slice helpers for the K-means cluster datapath.
package cluster_pkg;

   localparam int unsigned T      = 16;
   localparam int unsigned CH_N   = 3;
   localparam int unsigned CH_W   = 8;
   localparam int unsigned SUM_W  = 24;
   localparam int unsigned CNT_W  = 12;
   localparam int unsigned MEAN_W = CH_N * CH_W;
   localparam int unsigned ACC_W  = CH_N * SUM_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_ITER  = 2'd2,
      ST_DONE  = 2'd3
   } mu_state_t;

   // Bit offset of channel c of cluster i on a meanIn/meanOut style bus
   function automatic int unsigned mean_ofs(input int unsigned i, input int unsigned c);
      return i * MEAN_W + c * CH_W;
   endfunction

   // Bit offset of channel c sum of cluster i on the accumulator bus
   function automatic int unsigned acc_ofs(input int unsigned i, input int unsigned c);
      return i * ACC_W + c * SUM_W;
   endfunction

   // Clamp a full-width quotient to one channel value
   function automatic logic [CH_W-1:0] sat_ch(input logic [SUM_W-1:0] q);
      return (|q[SUM_W-1:CH_W]) ? '1 : q[CH_W-1:0];
   endfunction

endpackage

// File: rtl/serial_divider.sv
// 24/12 restoring divider, one quotient bit per cycle, MSB first.
// The load edge already performs the first step, so the quotient is complete
// (valid=1) after the load edge plus 23 further edges.
module serial_divider
   import cluster_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [SUM_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic [SUM_W-1:0] quotient,
   output logic             valid
);

   logic [SUM_W-1:0] r_quo;   // dividend bits shift out the top, quotient bits in the bottom
   logic [CNT_W:0]   r_rem;   // one spare bit keeps the shifted partial remainder
   logic [CNT_W-1:0] r_dsr;
   logic [4:0]       r_left;
   logic             r_run;

   logic [SUM_W-1:0] w_quo_in;
   logic [CNT_W:0]   w_rem_in;
   logic [CNT_W-1:0] w_dsr_in;
   logic [CNT_W:0]   w_rem_sh;
   logic [CNT_W:0]   w_diff;
   logic             w_fits;

   // One restoring step on either freshly loaded operands or the running state
   always_comb begin
      w_quo_in = load ? dividend : r_quo;
      w_rem_in = load ? '0 : r_rem;
      w_dsr_in = load ? divisor : r_dsr;
      w_rem_sh = {w_rem_in[CNT_W-1:0], w_quo_in[SUM_W-1]};
      w_diff   = w_rem_sh - {1'b0, w_dsr_in};
      w_fits   = w_rem_in[CNT_W] | (w_rem_sh >= {1'b0, w_dsr_in});
   end

   // Iteration state: load starts a run, then step until all bits are produced
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_quo  <= '0;
         r_rem  <= '0;
         r_dsr  <= '0;
         r_left <= '0;
         r_run  <= 1'b0;
      end else if (load || (r_run && (r_left != '0))) begin
         r_quo  <= {w_quo_in[SUM_W-2:0], w_fits};
         r_rem  <= w_fits ? w_diff : w_rem_sh;
         r_dsr  <= w_dsr_in;
         r_left <= load ? 5'(SUM_W - 1) : r_left - 5'd1;
         r_run  <= 1'b1;
      end
   end

   assign quotient = r_quo;
   assign valid    = r_run && (r_left == '0);

endmodule

// File: rtl/mean_update.sv
// K-means mean update: snapshots the engine's sums/counts, divides every
// channel sum by its cluster count on one shared serial divider, and
// publishes the new means, empty-cluster flags and a changed flag at once.
module mean_update
   import cluster_pkg::CH_N, cluster_pkg::CH_W, cluster_pkg::SUM_W, cluster_pkg::MEAN_W,
          cluster_pkg::mu_state_t, cluster_pkg::ST_IDLE, cluster_pkg::ST_SETUP,
          cluster_pkg::ST_ITER, cluster_pkg::ST_DONE, cluster_pkg::mean_ofs,
          cluster_pkg::sat_ch;
#(
   parameter int unsigned T     = cluster_pkg::T,
   parameter int unsigned ACC_W = cluster_pkg::ACC_W,
   parameter int unsigned CNT_W = cluster_pkg::CNT_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ACC_W*T-1:0]  accumolator,
   input  logic [CNT_W*T-1:0]  counters,
   input  logic [MEAN_W*T-1:0] meanIn,
   input  logic [T-1:0]        enabled,
   output logic                busy,
   output logic                done,
   output logic [MEAN_W*T-1:0] meanOut,
   output logic [T-1:0]        empty,
   output logic                changed
);

   localparam int unsigned IDX_W = (T > 1) ? $clog2(T) : 1;

   mu_state_t r_state, w_state_nx;

   logic [ACC_W*T-1:0]  r_snap_acc;
   logic [CNT_W*T-1:0]  r_snap_cnt;
   logic [MEAN_W*T-1:0] r_snap_mean;
   logic [T-1:0]        r_snap_en;
   logic [MEAN_W*T-1:0] r_stage;
   logic [MEAN_W*T-1:0] r_mean_out;
   logic [T-1:0]        r_empty;
   logic                r_changed;
   logic [IDX_W-1:0]    r_i;
   logic [1:0]          r_c;

   int unsigned         w_aofs;
   int unsigned         w_cofs;
   int unsigned         w_mofs;
   logic [SUM_W-1:0]    w_dividend;
   logic [CNT_W-1:0]    w_divisor;
   logic [SUM_W-1:0]    w_quo;
   logic                w_div_valid;
   logic                w_load;
   logic                w_last;
   logic [CH_W-1:0]     w_wb_val;
   logic [T-1:0]        w_empty;

   // Operand selection and writeback value for the current cluster/channel
   always_comb begin
      w_aofs     = 32'(r_i) * ACC_W + 32'(r_c) * SUM_W;
      w_cofs     = 32'(r_i) * CNT_W;
      w_mofs     = mean_ofs(32'(r_i), 32'(r_c));
      w_dividend = r_snap_acc[w_aofs +: SUM_W];
      w_divisor  = r_snap_cnt[w_cofs +: CNT_W];
      w_load     = (r_state == ST_SETUP);
      w_last     = (r_i == IDX_W'(T - 1)) && (r_c == 2'(CH_N - 1));
      if (r_snap_en[r_i] && (w_divisor != '0))
         w_wb_val = sat_ch(w_quo);
      else
         w_wb_val = r_snap_mean[w_mofs +: CH_W];
   end

   // Empty flags: enabled clusters that collected no pixels
   always_comb begin
      w_empty = '0;
      for (int unsigned k = 0; k < T; k++)
         w_empty[k] = r_snap_en[k] & (r_snap_cnt[k*CNT_W +: CNT_W] == '0);
   end

   serial_divider u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (w_load),
      .dividend (w_dividend),
      .divisor  (w_divisor),
      .quotient (w_quo),
      .valid    (w_div_valid)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   // FSM next state: SETUP+ITER per channel, DONE after the last channel
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nx = ST_SETUP;
         ST_SETUP: w_state_nx = ST_ITER;
         ST_ITER:  if (w_div_valid) w_state_nx = w_last ? ST_DONE : ST_SETUP;
         ST_DONE:  w_state_nx = ST_IDLE;
         default:  w_state_nx = ST_IDLE;
      endcase
   end

   // Input snapshot taken when a request is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_snap_acc  <= '0;
         r_snap_cnt  <= '0;
         r_snap_mean <= '0;
         r_snap_en   <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_snap_acc  <= accumolator;
         r_snap_cnt  <= counters;
         r_snap_mean <= meanIn;
         r_snap_en   <= enabled;
      end
   end

   // Walk indices and staging writeback at the end of each division
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i     <= '0;
         r_c     <= '0;
         r_stage <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_i <= '0;
         r_c <= '0;
      end else if ((r_state == ST_ITER) && w_div_valid) begin
         r_stage[w_mofs +: CH_W] <= w_wb_val;
         if (r_c == 2'(CH_N - 1)) begin
            r_c <= '0;
            r_i <= r_i + 1'b1;
         end else begin
            r_c <= r_c + 1'b1;
         end
      end
   end

   // Published results, updated together only in DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mean_out <= '0;
         r_empty    <= '0;
         r_changed  <= 1'b0;
      end else if (r_state == ST_DONE) begin
         r_mean_out <= r_stage;
         r_empty    <= w_empty;
         r_changed  <= (r_stage != r_snap_mean);
      end
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = (r_state == ST_DONE);
   assign meanOut = r_mean_out;
   assign empty   = r_empty;
   assign changed = r_changed;

endmodule
